// File: rtl/mask32_sched_pkg.sv
// Shared types and constants for the mask32 burst-engine scheduler.
package mask32_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_CHECK,
    S_FINISH
  } sched_state_t;

  localparam int unsigned STAT_AXI_ERR    = 0;
  localparam int unsigned STAT_TIMEOUT    = 1;
  localparam int unsigned STAT_ABORTED    = 2;
  localparam int unsigned STAT_WIDTH      = 3;
  localparam int unsigned DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/mask32_sched_watchdog.sv
// Loadable down-counter watchdog: clear reloads, enable counts down, expire flags zero.
module mask32_sched_watchdog #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/mask32_txn_scheduler.sv
// Multi-burst sequencer for the mask32 AXI4 master engine: issue, await done edge,
// retry on error, watchdog timeout and deferred abort, with sticky status.
module mask32_txn_scheduler
  import mask32_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned BURST_BYTES    = 32,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_num_bursts,
  input  logic                  abort,
  output logic                  txn_init,
  output logic [ADDR_WIDTH-1:0] txn_addr,
  input  logic                  txn_done,
  input  logic                  txn_error,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [STAT_WIDTH-1:0] status,
  output logic [CNT_WIDTH-1:0]  bursts_done
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RT_W = $clog2(MAX_RETRY + 2);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RT_W-1:0] RETRY_MAX = RT_W'(MAX_RETRY);

  sched_state_t          state;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [RT_W-1:0]       retry;
  logic                  done_q;
  logic                  err_q;
  logic                  abort_q;
  logic                  wd_expire;
  logic                  done_edge;

  assign done_edge = txn_done & ~done_q;

  mask32_sched_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .clear      (state == S_ISSUE),
    .enable     (state == S_WAIT_DONE),
    .load_value (WD_LIMIT),
    .expire     (wd_expire)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      txn_init    <= 1'b0;
      txn_addr    <= '0;
      done_pulse  <= 1'b0;
      status      <= '0;
      bursts_done <= '0;
      remaining   <= '0;
      retry       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      txn_init   <= 1'b0;
      done_pulse <= 1'b0;
      done_q     <= txn_done;
      if ((state != S_IDLE) && abort) abort_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            txn_addr    <= cmd_base_addr;
            remaining   <= cmd_num_bursts;
            status      <= '0;
            bursts_done <= '0;
            retry       <= '0;
            abort_q     <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            if (cmd_num_bursts == '0) begin
              state <= S_FINISH;
            end else begin
              state    <= S_ISSUE;
              txn_init <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          // Arm the edge detector high so a done level left over from the
          // previous burst is not mistaken for this burst's completion.
          done_q <= 1'b1;
          state  <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (done_edge) begin
            err_q <= txn_error;
            state <= S_CHECK;
          end else if (wd_expire) begin
            status[STAT_TIMEOUT] <= 1'b1;
            state                <= S_FINISH;
          end
        end

        S_CHECK: begin
          if (err_q) begin
            if (retry < RETRY_MAX) begin
              retry    <= retry + RT_W'(1);
              state    <= S_ISSUE;
              txn_init <= 1'b1;
            end else begin
              status[STAT_AXI_ERR] <= 1'b1;
              state                <= S_FINISH;
            end
          end else begin
            bursts_done <= bursts_done + CNT_WIDTH'(1);
            remaining   <= remaining - CNT_WIDTH'(1);
            txn_addr    <= txn_addr + ADDR_WIDTH'(BURST_BYTES);
            retry       <= '0;
            // Completion of the final burst outranks a pending abort.
            if (remaining == CNT_WIDTH'(1)) begin
              state <= S_FINISH;
            end else if (abort_q || abort) begin
              status[STAT_ABORTED] <= 1'b1;
              state                <= S_FINISH;
            end else begin
              state    <= S_ISSUE;
              txn_init <= 1'b1;
            end
          end
        end

        S_FINISH: begin
          done_pulse <= 1'b1;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask32_txn_scheduler.sv
// Directed, table-driven bench for mask32_txn_scheduler with a behavioural burst engine.
module tb_mask32_txn_scheduler;

  localparam int unsigned AW      = 32;
  localparam int unsigned CW      = 16;
  localparam int unsigned TO      = 64;
  localparam int          ENG_LAT = 20;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [CW-1:0] cmd_num_bursts = '0;
  logic          abort;
  logic          txn_init;
  logic [AW-1:0] txn_addr;
  logic          txn_done;
  logic          txn_error;
  logic          busy;
  logic          done_pulse;
  logic [2:0]    status;
  logic [CW-1:0] bursts_done;

  always #5 ACLK = ~ACLK;

  mask32_txn_scheduler #(
    .ADDR_WIDTH     (AW),
    .BURST_BYTES    (32),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (2)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_base_addr  (cmd_base_addr),
    .cmd_num_bursts (cmd_num_bursts),
    .abort          (abort),
    .txn_init       (txn_init),
    .txn_addr       (txn_addr),
    .txn_done       (txn_done),
    .txn_error      (txn_error),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .status         (status),
    .bursts_done    (bursts_done)
  );

  int applied = 0;
  int miscompares = 0;

  // Engine configuration, written by the main sequence between commands.
  int eng_base = 0;
  int eng_nerr = 0;
  int eng_abort_at = 0;
  bit eng_hang = 1'b0;
  int eng_n;
  int eng_cnt;
  bit cur_err;

  // Engine: drops done on init, raises done (with error) ENG_LAT cycles later.
  initial begin
    txn_done = 1'b0; txn_error = 1'b0; abort = 1'b0;
    eng_n = 0; eng_cnt = 0; cur_err = 1'b0;
    forever begin
      @(negedge ACLK);
      abort = 1'b0;
      if (!ARESETN) begin
        txn_done = 1'b0; txn_error = 1'b0; eng_cnt = 0;
      end else if (txn_init) begin
        eng_n++;
        txn_done  = 1'b0;
        txn_error = 1'b0;
        eng_cnt   = ENG_LAT;
        cur_err   = ((eng_n - eng_base) <= eng_nerr);
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (((eng_n - eng_base) == eng_abort_at) && (eng_cnt == 10)) abort = 1'b1;
        if ((eng_cnt == 0) && !eng_hang) begin
          txn_done  = 1'b1;
          txn_error = cur_err;
        end
      end
    end
  end

  logic [AW-1:0] init_log[$];
  int done_cnt = 0;

  initial begin
    forever begin
      @(negedge ACLK);
      if (txn_init) init_log.push_back(txn_addr);
      if (done_pulse) done_cnt++;
    end
  end

  typedef struct {
    string           name;
    logic [AW-1:0]   base;
    logic [CW-1:0]   num;
    int              nerr;
    int              abort_at;
    bit              hang;
    logic [2:0]      exp_status;
    logic [CW-1:0]   exp_bursts;
    int              n_inits;
    logic [3:0][AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string name, input logic [AW-1:0] base,
                                  input logic [CW-1:0] num, input int nerr, input int abort_at,
                                  input bit hang, input logic [2:0] st, input logic [CW-1:0] nb,
                                  input int ni, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                  input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    vec_t v;
    v.name = name; v.base = base; v.num = num; v.nerr = nerr; v.abort_at = abort_at;
    v.hang = hang; v.exp_status = st; v.exp_bursts = nb; v.n_inits = ni;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic [AW-1:0] base, input logic [CW-1:0] num);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_base_addr = base; cmd_num_bursts = num;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int start_idx;
    int dc0;
    bit got;
    start_idx    = init_log.size();
    dc0          = done_cnt;
    eng_base     = eng_n;
    eng_nerr     = v.nerr;
    eng_abort_at = v.abort_at;
    eng_hang     = v.hang;
    issue_cmd(v.base, v.num);
    chk({v.name, ".busy"}, {31'd0, busy}, 32'd1);
    chk({v.name, ".cmd_ready_low"}, {31'd0, cmd_ready}, 32'd0);
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge ACLK);
      if (done_pulse) got = 1'b1;
    end
    chk({v.name, ".done_seen"}, {31'd0, got}, 32'd1);
    chk({v.name, ".status"}, {29'd0, status}, {29'd0, v.exp_status});
    chk({v.name, ".bursts_done"}, {16'd0, bursts_done}, {16'd0, v.exp_bursts});
    chk({v.name, ".n_inits"}, init_log.size() - start_idx, v.n_inits);
    for (int i = 0; i < v.n_inits && (start_idx + i) < init_log.size(); i++)
      chk($sformatf("%s.addr%0d", v.name, i), init_log[start_idx + i], v.exp_addr[i]);
    repeat (3) @(negedge ACLK);
    chk({v.name, ".one_done"}, done_cnt - dc0, 1);
    chk({v.name, ".idle_ready"}, {30'd0, cmd_ready, busy}, 32'd2);
    chk({v.name, ".status_held"}, {29'd0, status}, {29'd0, v.exp_status});
  endtask

  initial begin
    int lat;
    int dc0;
    bit got;

    add_vec("t1_three", 32'h0000_1000, 16'd3, 0, 0, 1'b0, 3'b000, 16'd3, 3,
            32'h0000_1000, 32'h0000_1020, 32'h0000_1040, 32'h0);
    add_vec("t2_zero", 32'h0000_1000, 16'd0, 0, 0, 1'b0, 3'b000, 16'd0, 0,
            32'h0, 32'h0, 32'h0, 32'h0);
    add_vec("t3_retry_ok", 32'h0000_1000, 16'd2, 2, 0, 1'b0, 3'b000, 16'd2, 4,
            32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1020);
    add_vec("t3_axi_err", 32'h0000_1000, 16'd2, 3, 0, 1'b0, 3'b001, 16'd0, 3,
            32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0);
    add_vec("t4_abort", 32'h0000_1000, 16'd4, 0, 2, 1'b0, 3'b100, 16'd2, 2,
            32'h0000_1000, 32'h0000_1020, 32'h0, 32'h0);
    add_vec("abort_last", 32'h0000_1000, 16'd2, 0, 2, 1'b0, 3'b000, 16'd2, 2,
            32'h0000_1000, 32'h0000_1020, 32'h0, 32'h0);
    add_vec("abort_err", 32'h0000_2000, 16'd2, 1, 1, 1'b0, 3'b100, 16'd1, 2,
            32'h0000_2000, 32'h0000_2000, 32'h0, 32'h0);
    add_vec("t5_timeout", 32'h0000_1000, 16'd1, 0, 0, 1'b1, 3'b010, 16'd0, 1,
            32'h0000_1000, 32'h0, 32'h0, 32'h0);
    add_vec("t5_wrap", 32'hFFFF_FFE0, 16'd2, 0, 0, 1'b0, 3'b000, 16'd2, 2,
            32'hFFFF_FFE0, 32'h0000_0000, 32'h0, 32'h0);

    // Reset values (asynchronous assertion).
    #2 ARESETN = 1'b0;
    #1;
    chk("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst.others", {txn_addr[7:0], 6'd0, busy, txn_init, done_pulse, status, bursts_done[11:0]}, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero-burst latency: done_pulse two cycles after the accept.
    eng_base = eng_n; eng_nerr = 0; eng_abort_at = 0; eng_hang = 1'b0;
    issue_cmd(32'h0000_5000, 16'd0);
    lat = 1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (done_pulse) got = 1'b1;
      else begin @(negedge ACLK); lat++; end
    end
    chk("zero.latency", lat, 2);
    repeat (2) @(negedge ACLK);

    // Watchdog: done_pulse TO+2 cycles after the txn_init cycle.
    eng_base = eng_n; eng_hang = 1'b1;
    issue_cmd(32'h0000_6000, 16'd1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (txn_init) got = 1'b1;
      else @(negedge ACLK);
    end
    chk("to.init_seen", {31'd0, got}, 32'd1);
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge ACLK);
      lat++;
      if (done_pulse) got = 1'b1;
    end
    chk("to.latency", lat, TO + 2);
    chk("to.status", {29'd0, status}, 32'd2);
    repeat (2) @(negedge ACLK);

    // Reset in the middle of burst 2 of a 3-burst command.
    eng_base = eng_n; eng_hang = 1'b0;
    issue_cmd(32'h0000_3000, 16'd3);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge ACLK);
      if ((eng_n - eng_base) == 2) got = 1'b1;
    end
    chk("mid.reach_burst2", {31'd0, got}, 32'd1);
    repeat (5) @(negedge ACLK);
    chk("mid.busy_before", {31'd0, busy}, 32'd1);
    dc0 = done_cnt;
    ARESETN = 1'b0;
    #1;
    chk("mid.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid.busy", {31'd0, busy}, 32'd0);
    chk("mid.bursts_done", {16'd0, bursts_done}, 32'd0);
    chk("mid.txn_addr", txn_addr, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (40) @(negedge ACLK);
    chk("mid.no_done", done_cnt - dc0, 0);

    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

endmodule
